led_cube_layer_scan: RTL and testbench
======================================

// Module: led_cube_layer_scan
// PURPOSE
//  Reader side of the 8x8x8 cube frame buffer. Drives frame_addr and samples the returned byte
//  (data_to_latch, combinational, same cycle). Loads eight column bytes per layer into the eight
//  column latches, then enables that layer for a dwell time. Sequences layers 0..7 continuously.
//  Sits between the stream/pattern frame buffer and the latch/layer-driver pins.
// PARAMETERS
//  BLANK_CYCLES  4     cycles all layers off before loading a layer (anti-ghosting); >=1
//  LAYER_DWELL   1000  cycles a loaded layer stays enabled; >=1
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  reset; synchronous, active-low
//  enable         in   1  scan enable; low forces IDLE
//  data_to_latch  in   8  byte read from frame buffer at frame_addr (combinational)
//  frame_addr     out  6  {layer[2:0], col[2:0]} read address to frame buffer
//  latch_data     out  8  byte presented to the column-latch data bus
//  latch_clk      out  8  one-hot latch strobe, bit = column
//  layer_en       out  8  one-hot layer enable, bit = layer
//  frame_done     out  1  1-cycle pulse when layer 7 dwell completes
//  busy           out  1  high in every state except IDLE
// BEHAVIOUR
//  - Decided: clock is clk; reset is rst_n, synchronous, active-low.
//  - All outputs are registered. Reset: state=IDLE, layer=0, col=0, counters=0, all outputs 0.
//  - FSM states: IDLE, BLANK, SETUP, STROBE, DWELL.
//  - IDLE: all outputs 0. When enable=1, go to BLANK with layer=0.
//  - BLANK: layer_en=0, latch_clk=0. Runs BLANK_CYCLES cycles, then goes to SETUP with col=0.
//  - SETUP: frame_addr={layer,col}, latch_clk=0.
//      At the edge leaving SETUP, latch_data<=data_to_latch.
//  - STROBE: latch_clk[col]=1 for exactly 1 cycle. latch_data is stable across the whole cycle.
//      Then: if col==7, go to DWELL; else col++ and go to SETUP.
//  - Load phase is 16 cycles per layer: 8 columns x (SETUP + STROBE).
//  - DWELL: layer_en[layer]=1 for LAYER_DWELL cycles. latch_clk=0.
//      latch_data and frame_addr hold their last values.
//  - End of DWELL: layer wraps 7->0 modulo 8, then go to BLANK.
//  - frame_done: pulses 1 cycle when layer 7 dwell ends.
//      The pulse coincides with the first BLANK cycle of layer 0.
//  - Timing: layer period = BLANK_CYCLES+16+LAYER_DWELL cycles; frame period = 8x layer period.
//  - Counters are sized $clog2(max(BLANK_CYCLES,LAYER_DWELL))+1 bits and never wrap mid-phase.
//  - enable low in any non-IDLE state: go to IDLE on the next edge.
//      That same edge clears layer_en, latch_clk, frame_addr, latch_data and busy.
//      frame_done does not pulse. Re-enable restarts at layer 0, BLANK.
//  - rst_n low mid-scan overrides everything: reset values on the next edge.
//  - At most one bit of layer_en is set at any time; at most one bit of latch_clk is set at any time.
//  - layer_en and latch_clk are never both nonzero in the same cycle.
// CONFIGURATION
//  LED_CUBE_SCAN_DIM_EN defined:
//   - Adds input brightness[7:0]. brightness is sampled on DWELL entry.
//   - An 8-bit pwm counter clears on DWELL entry and increments each DWELL cycle, wrapping 255->0.
//   - layer_en[layer] = (pwm < brightness_s), except brightness_s==8'hFF forces it fully on.
//   - brightness_s==0 keeps the layer dark for the whole dwell.
//   - DWELL length is unchanged.
//  LED_CUBE_SCAN_DIM_EN undefined:
//   - No brightness port; layer_en[layer]=1 for the full dwell.
// TESTING (BLANK_CYCLES=2, LAYER_DWELL=4 -> layer period 22, frame period 176)
//  1. Reset held 3 cycles with enable=1 -> all outputs 0 and busy=0 during reset;
//     first BLANK cycle on the 1st edge after release.
//  2. Buffer returns data=addr^8'hA5, enable=1 -> layer 3 col 5: frame_addr=6'h1D,
//     then latch_clk=8'h20 with latch_data=8'hB8.
//  3. Free run -> layer_en sequence 01,02,..,80,01; each asserted for exactly 4 cycles;
//     frame_done pulses every 176 cycles.
//  4. Deassert enable during STROBE of layer 2 col 4 -> next cycle all outputs 0, no frame_done;
//     re-enable -> BLANK at layer 0.
//  5. DIM_EN, brightness=2, LAYER_DWELL=4 -> layer_en high 2 of 4 dwell cycles;
//     brightness=0 -> 0 cycles; brightness=FF -> 4 cycles.
//  6. Checkers, all runs: latch_clk and layer_en never overlap;
//     $onehot0 holds on latch_clk and on layer_en.

Source files
------------

// File: rtl/led_cube_layer_scan.sv
// Layer-scan reader for an 8x8x8 LED cube: loads eight column latches per layer from the frame
// buffer, then lights that layer for a dwell. Define LED_CUBE_SCAN_DIM_EN for per-dwell PWM dimming.
module led_cube_layer_scan #(
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned LAYER_DWELL  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
`ifdef LED_CUBE_SCAN_DIM_EN
  input  logic [7:0] brightness,
`endif
  input  logic [7:0] data_to_latch,
  output logic [5:0] frame_addr,
  output logic [7:0] latch_data,
  output logic [7:0] latch_clk,
  output logic [7:0] layer_en,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned MaxCycles = (BLANK_CYCLES > LAYER_DWELL) ? BLANK_CYCLES : LAYER_DWELL;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(LAYER_DWELL - 1);

  typedef enum logic [2:0] {StIdle, StBlank, StSetup, StStrobe, StDwell} state_e;

  state_e          state_q, state_d;
  logic [2:0]      layer_q, layer_d;
  logic [2:0]      col_q, col_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      frame_addr_q, frame_addr_d;
  logic [7:0]      latch_data_q, latch_data_d;
  logic [7:0]      latch_clk_q, latch_clk_d;
  logic [7:0]      layer_en_q, layer_en_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q, busy_d;

  // Layer-on qualifier for the first and subsequent dwell cycles.
  logic dwell_on_first, dwell_on_next;

`ifdef LED_CUBE_SCAN_DIM_EN
  logic [7:0] pwm_q, pwm_d;
  logic [7:0] bright_q, bright_d;
  logic [7:0] pwm_inc;

  assign pwm_inc        = pwm_q + 8'd1;
  // Full scale forces the layer fully on rather than dark for one cycle in 256.
  assign dwell_on_first = (brightness == 8'hFF) || (brightness != 8'd0);
  assign dwell_on_next  = (bright_q == 8'hFF) || (pwm_inc < bright_q);
`else
  assign dwell_on_first = 1'b1;
  assign dwell_on_next  = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    frame_addr_d = frame_addr_q;
    latch_data_d = latch_data_q;
    latch_clk_d  = 8'h00;
    layer_en_d   = 8'h00;
    frame_done_d = 1'b0;
    busy_d       = 1'b1;
`ifdef LED_CUBE_SCAN_DIM_EN
    pwm_d        = pwm_q;
    bright_d     = bright_q;
`endif

    unique case (state_q)
      StIdle: begin
        state_d = StBlank;
        layer_d = 3'd0;
        col_d   = 3'd0;
        cnt_d   = '0;
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d      = StSetup;
          col_d        = 3'd0;
          cnt_d        = '0;
          frame_addr_d = {layer_q, 3'd0};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSetup: begin
        state_d      = StStrobe;
        latch_data_d = data_to_latch;
        latch_clk_d  = 8'h01 << col_q;
      end
      StStrobe: begin
        if (col_q == 3'd7) begin
          state_d    = StDwell;
          cnt_d      = '0;
          layer_en_d = dwell_on_first ? (8'h01 << layer_q) : 8'h00;
`ifdef LED_CUBE_SCAN_DIM_EN
          pwm_d      = 8'd0;
          bright_d   = brightness;
`endif
        end else begin
          state_d      = StSetup;
          col_d        = col_q + 3'd1;
          frame_addr_d = {layer_q, col_q + 3'd1};
        end
      end
      StDwell: begin
        if (cnt_q == DwellLast) begin
          state_d      = StBlank;
          cnt_d        = '0;
          layer_d      = layer_q + 3'd1;
          frame_done_d = (layer_q == 3'd7);
        end else begin
          cnt_d      = cnt_q + 1'b1;
          layer_en_d = dwell_on_next ? (8'h01 << layer_q) : 8'h00;
`ifdef LED_CUBE_SCAN_DIM_EN
          pwm_d      = pwm_inc;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable aborts the scan from any state on the next edge.
    if (!enable) begin
      state_d      = StIdle;
      layer_d      = 3'd0;
      col_d        = 3'd0;
      cnt_d        = '0;
      frame_addr_d = 6'd0;
      latch_data_d = 8'h00;
      latch_clk_d  = 8'h00;
      layer_en_d   = 8'h00;
      frame_done_d = 1'b0;
      busy_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      layer_q      <= 3'd0;
      col_q        <= 3'd0;
      cnt_q        <= '0;
      frame_addr_q <= 6'd0;
      latch_data_q <= 8'h00;
      latch_clk_q  <= 8'h00;
      layer_en_q   <= 8'h00;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LED_CUBE_SCAN_DIM_EN
      pwm_q        <= 8'd0;
      bright_q     <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      frame_addr_q <= frame_addr_d;
      latch_data_q <= latch_data_d;
      latch_clk_q  <= latch_clk_d;
      layer_en_q   <= layer_en_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
`ifdef LED_CUBE_SCAN_DIM_EN
      pwm_q        <= pwm_d;
      bright_q     <= bright_d;
`endif
    end
  end

  assign frame_addr = frame_addr_q;
  assign latch_data = latch_data_q;
  assign latch_clk  = latch_clk_q;
  assign layer_en   = layer_en_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_led_cube_layer_scan.sv
// Scoreboard bench for led_cube_layer_scan (BLANK_CYCLES=2, LAYER_DWELL=4: layer 22, frame 176).
module tb_led_cube_layer_scan;

  localparam int LayerPer = 22;
  localparam int FramePer = 176;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] data_to_latch;
  logic [5:0] frame_addr;
  logic [7:0] latch_data, latch_clk, layer_en;
  logic       frame_done, busy;
`ifdef LED_CUBE_SCAN_DIM_EN
  logic [7:0] brightness = 8'hFF;
`endif

  led_cube_layer_scan #(.BLANK_CYCLES(2), .LAYER_DWELL(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
`ifdef LED_CUBE_SCAN_DIM_EN
    .brightness    (brightness),
`endif
    .data_to_latch (data_to_latch),
    .frame_addr    (frame_addr),
    .latch_data    (latch_data),
    .latch_clk     (latch_clk),
    .layer_en      (layer_en),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: combinational read, data = addr ^ 8'hA5.
  assign data_to_latch = {2'b00, frame_addr} ^ 8'hA5;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [7:0] clk_v; logic [7:0] data; logic [5:0] addr; int t;} strobe_t;
  typedef struct {logic [7:0] en; int t;} layer_t;
  strobe_t sq[$];
  layer_t  lq[$];
  int      fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected strobes, dwells and frame_done edges for a scan starting in BLANK at cycle base.
  task automatic push_expect(input int base, input int limit, input int frames);
    for (int f = 0; f < frames; f++) begin
      for (int l = 0; l < 8; l++) begin
        for (int c = 0; c < 8; c++) begin
          strobe_t s;
          s.t      = base + f * FramePer + l * LayerPer + 3 + 2 * c;
          s.addr   = 6'(l * 8 + c);
          s.data   = {2'b00, s.addr} ^ 8'hA5;
          s.clk_v  = 8'h01 << c;
          if (s.t <= limit) sq.push_back(s);
        end
        begin
          layer_t e;
          e.t  = base + f * FramePer + l * LayerPer + 18;
          e.en = 8'h01 << l;
          if (e.t <= limit) lq.push_back(e);
        end
      end
      if (base + (f + 1) * FramePer <= limit) fq.push_back(base + (f + 1) * FramePer);
    end
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    if (mon_on && latch_clk != 8'h00) begin
      if (sq.size() == 0) begin
        check("unexpected_strobe", {24'd0, latch_clk}, 32'd0);
      end else begin
        strobe_t s;
        s = sq.pop_front();
        check("strobe_latch_clk", {24'd0, latch_clk}, {24'd0, s.clk_v});
        check("strobe_latch_data", {24'd0, latch_data}, {24'd0, s.data});
        check("strobe_frame_addr", {26'd0, frame_addr}, {26'd0, s.addr});
        check("strobe_cycle", cyc, s.t);
      end
    end
  end

  // Layer-enable monitor: start cycle, value and dwell length.
  logic [7:0] prev_en = 8'h00;
  int         run = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      if (layer_en != 8'h00 && layer_en != prev_en) begin
        if (lq.size() == 0) begin
          check("unexpected_layer_en", {24'd0, layer_en}, 32'd0);
        end else begin
          layer_t e;
          e = lq.pop_front();
          check("layer_en_value", {24'd0, layer_en}, {24'd0, e.en});
          check("layer_en_cycle", cyc, e.t);
        end
      end
      if (layer_en != 8'h00) run++;
      if (layer_en == 8'h00 && prev_en != 8'h00) begin
        check("dwell_length", run, 4);
        run = 0;
      end
    end else begin
      run = 0;
    end
    prev_en = layer_en;
  end

  // frame_done monitor.
  always @(negedge clk) begin
    if (mon_on && frame_done) begin
      if (fq.size() == 0) check("unexpected_frame_done", cyc, 0);
      else check("frame_done_cycle", cyc, fq.pop_front());
    end
  end

  // Structural invariants, every cycle.
  always @(negedge clk) begin
    check("onehot0_latch_clk", {31'd0, $onehot0(latch_clk)}, 32'd1);
    check("onehot0_layer_en", {31'd0, $onehot0(layer_en)}, 32'd1);
    check("no_overlap", {31'd0, (latch_clk != 8'h00) && (layer_en != 8'h00)}, 32'd0);
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_frame_addr"}, {26'd0, frame_addr}, 32'd0);
    check({name, "_latch_data"}, {24'd0, latch_data}, 32'd0);
    check({name, "_latch_clk"}, {24'd0, latch_clk}, 32'd0);
    check({name, "_layer_en"}, {24'd0, layer_en}, 32'd0);
    check({name, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  int e0, e1;

  initial begin
    // Reset held with enable high.
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    e0 = cyc;
    check("first_blank_busy", {31'd0, busy}, 32'd1);
    check("first_blank_layer_en", {24'd0, layer_en}, 32'd0);
    push_expect(e0, e0 + 407, 3);
    mon_on = 1'b1;

    // Layer 3 column 5 load.
    wait_cyc(e0 + 78);
    check("l3c5_setup_addr", {26'd0, frame_addr}, 32'h1D);
    check("l3c5_setup_clk", {24'd0, latch_clk}, 32'h00);
    wait_cyc(e0 + 79);
    check("l3c5_strobe_clk", {24'd0, latch_clk}, 32'h20);
    check("l3c5_strobe_data", {24'd0, latch_data}, 32'hB8);

    // Abort during STROBE of layer 2 column 4 in the third frame.
    wait_cyc(e0 + 407);
    check("l2c4_strobe_clk", {24'd0, latch_clk}, 32'h10);
    check("l2c4_strobe_addr", {26'd0, frame_addr}, 32'h14);
    enable = 1'b0;
    @(negedge clk);
    check_idle("abort");
    @(negedge clk);
    check_idle("abort_hold");
    enable = 1'b1;
    @(negedge clk);
    e1 = cyc;
    check("restart_busy", {31'd0, busy}, 32'd1);
    push_expect(e1, e1 + 30, 1);
    wait_cyc(e1 + 30);
    mon_on = 1'b0;
    check("strobe_queue_empty", sq.size(), 0);
    check("layer_queue_empty", lq.size(), 0);
    check("frame_done_queue_empty", fq.size(), 0);

`ifdef LED_CUBE_SCAN_DIM_EN
    begin
      logic [7:0] levels [3] = '{8'd2, 8'd0, 8'hFF};
      int         want   [3] = '{2, 0, 4};
      for (int k = 0; k < 3; k++) begin
        int on_cnt;
        enable = 1'b0;
        @(negedge clk);
        brightness = levels[k];
        enable = 1'b1;
        on_cnt = 0;
        repeat (LayerPer) begin
          @(negedge clk);
          if (layer_en != 8'h00) on_cnt++;
        end
        check("dim_on_cycles", on_cnt, want[k]);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
